// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes,
// ALU operation codes (also consumed by the ALU) and mux/immediate selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    EXECUTEU = 4'd8,
    ALUWB    = 4'd9,
    BEQ      = 4'd10,
    JAL      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_PASS  = 2'b11
  } aluop_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode, independent of FSM state.
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_LW, OP_ITYPE: imm_sel = IMM_I;
      OP_SW:           imm_sel = IMM_S;
      OP_BEQ:          imm_sel = IMM_B;
      OP_JAL:          imm_sel = IMM_J;
      OP_LUI:          imm_sel = IMM_U;
      default:         imm_sel = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the controller and the datapath: instruction fields and Zero
// flow in, enables, mux selects, ALU code and debug state flow out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational mapping of ALUOp and instruction function fields to the
// 3-bit ALU operation code.
module alu_decoder
  import riscv_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:  alu_control = ALU_ADD;
      ALUOP_SUB:  alu_control = ALU_SUB;
      ALUOP_PASS: alu_control = ALU_PASS;
      default: begin
        case (funct3)
          // op[5] separates R-type from I-type, so addi never becomes sub.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V datapath; drives enables, mux
// selects, immediate format and ALU code from the current state and opcode.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_t     state_reg, state_next;
  aluop_t     alu_op;
  logic       pc_update, branch;
  logic       mem_write_raw, ir_write_raw, reg_write_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTER;
          OP_ITYPE:     state_next = EXECUTEI;
          OP_LUI:       state_next = EXECUTEU;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = MEMWB;
      EXECUTER, EXECUTEI, EXECUTEU, JAL: state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    case (state_reg)
      FETCH: begin
        ir_write_raw  = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        pc_update     = 1'b1;
      end
      DECODE: begin
        // Branch target is precomputed from OldPC while the opcode decodes.
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
      end
      MEMREAD: bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc    = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTER: begin
        bus.ALUSrcA = SRCA_RS1;
        alu_op      = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
      end
      EXECUTEU: begin
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_PASS;
      end
      ALUWB: reg_write_raw = 1'b1;
      BEQ: begin
        bus.ALUSrcA = SRCA_RS1;
        alu_op      = ALUOP_SUB;
        branch      = 1'b1;
      end
      JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pc_update   = 1'b1;
      end
      default: ;
    endcase
  end

  // The state register resets to FETCH, whose strobes are active; gate them
  // so nothing writes while rst_n is held low.
  assign bus.PCWrite  = rst_n & (pc_update | (branch & bus.Zero));
  assign bus.MemWrite = rst_n & mem_write_raw;
  assign bus.IRWrite  = rst_n & ir_write_raw;
  assign bus.RegWrite = rst_n & reg_write_raw;
  assign bus.ImmSrc   = imm_sel(bus.op);
  assign bus.State    = state_reg;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .op5         (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (bus.ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: table of instructions with
// hand-computed state traces, plus reset and multi-cycle corner sequences.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         cycles;
    logic [19:0] seq;   // nibble c = expected State in cycle c, F = unused
    logic [2:0] alu;    // ALUControl in cycle 2
    logic       pcw2;   // PCWrite in cycle 2
    logic [2:0] imm;
    logic       memw;   // any MemWrite during the instruction
    logic       regw;   // any RegWrite during the instruction
  } vec_t;

  localparam int NV = 13;
  vec_t v[NV];

  initial begin
    int cnt;
    logic memw_seen, regw_seen, done;

    v[0]  = '{"lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 5, 20'h43210, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1};
    v[1]  = '{"sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 4, 20'hF5210, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0};
    v[2]  = '{"sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 4, 20'hF9610, 3'b001, 1'b0, 3'b000, 1'b0, 1'b1};
    v[3]  = '{"addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, 20'hF9710, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1};
    v[4]  = '{"slt",     7'b0110011, 3'b010, 1'b1, 1'b0, 4, 20'hF9610, 3'b101, 1'b0, 3'b000, 1'b0, 1'b1};
    v[5]  = '{"or",      7'b0110011, 3'b110, 1'b1, 1'b0, 4, 20'hF9610, 3'b011, 1'b0, 3'b000, 1'b0, 1'b1};
    v[6]  = '{"andi",    7'b0010011, 3'b111, 1'b0, 1'b0, 4, 20'hF9710, 3'b010, 1'b0, 3'b000, 1'b0, 1'b1};
    v[7]  = '{"sll_add", 7'b0110011, 3'b001, 1'b0, 1'b0, 4, 20'hF9610, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1};
    v[8]  = '{"lui",     7'b0110111, 3'b000, 1'b0, 1'b0, 4, 20'hF9810, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1};
    v[9]  = '{"beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1, 3, 20'hFFA10, 3'b001, 1'b1, 3'b010, 1'b0, 1'b0};
    v[10] = '{"beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, 3, 20'hFFA10, 3'b001, 1'b0, 3'b010, 1'b0, 1'b0};
    v[11] = '{"jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 4, 20'hF9B10, 3'b000, 1'b1, 3'b011, 1'b0, 1'b1};
    v[12] = '{"unsup",   7'b1111111, 3'b000, 1'b0, 1'b1, 2, 20'hFFF10, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};

    // Reset held for three cycles
    rst_n        = 1'b0;
    bus.op       = 7'b0000011;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Zero     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_state",    bus.State,    4'd0);
      chk("rst_pcwrite",  bus.PCWrite,  1'b0);
      chk("rst_irwrite",  bus.IRWrite,  1'b0);
      chk("rst_memwrite", bus.MemWrite, 1'b0);
      chk("rst_regwrite", bus.RegWrite, 1'b0);
      chk("rst_alusrcb",  bus.ALUSrcB,  2'b10);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_irwrite", bus.IRWrite,    1'b1);
    chk("post_rst_pcwrite", bus.PCWrite,    1'b1);
    chk("post_rst_alusrcb", bus.ALUSrcB,    2'b10);
    chk("post_rst_aluctl",  bus.ALUControl, 3'b000);
    $display("reset: state=%0d irwrite=%0b pcwrite=%0b", bus.State, bus.IRWrite, bus.PCWrite);

    // Table-driven instructions, each starting in FETCH
    for (int i = 0; i < NV; i++) begin
      bus.op       = v[i].op;
      bus.funct3   = v[i].f3;
      bus.funct7b5 = v[i].f7;
      bus.Zero     = v[i].zero;
      #1;
      cnt       = 0;
      memw_seen = 1'b0;
      regw_seen = 1'b0;
      done      = 1'b0;
      while (!done) begin
        if (cnt < 5) chk($sformatf("%s_state%0d", v[i].name, cnt), bus.State, v[i].seq[cnt*4 +: 4]);
        if (cnt == 1) chk($sformatf("%s_immsrc", v[i].name), bus.ImmSrc, v[i].imm);
        if (cnt == 2) begin
          chk($sformatf("%s_aluctl", v[i].name), bus.ALUControl, v[i].alu);
          chk($sformatf("%s_pcwrite", v[i].name), bus.PCWrite, v[i].pcw2);
        end
        memw_seen = memw_seen | bus.MemWrite;
        regw_seen = regw_seen | bus.RegWrite;
        cnt++;
        @(negedge clk); #1;
        if (bus.State == 4'd0 || cnt >= 10) done = 1'b1;
      end
      chk($sformatf("%s_cycles", v[i].name),   cnt,       v[i].cycles);
      chk($sformatf("%s_memwrite", v[i].name), memw_seen, v[i].memw);
      chk($sformatf("%s_regwrite", v[i].name), regw_seen, v[i].regw);
      $display("instr %s: op=%b cycles=%0d memw=%0b regw=%0b", v[i].name, v[i].op, cnt, memw_seen, regw_seen);
    end

    // lw memory-phase mux selects
    bus.op = 7'b0000011;
    bus.Zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("lw_memread_state",  bus.State,     4'd3);
    chk("lw_memread_adrsrc", bus.AdrSrc,    1'b1);
    chk("lw_memread_result", bus.ResultSrc, 2'b00);
    @(negedge clk); #1;
    chk("lw_memwb_result",   bus.ResultSrc, 2'b01);
    chk("lw_memwb_regwrite", bus.RegWrite,  1'b1);
    @(negedge clk); #1;
    chk("lw_back_fetch",     bus.State,     4'd0);
    $display("lw phases: state=%0d", bus.State);

    // Reset pulsed in MEMWRITE
    bus.op = 7'b0100011;
    repeat (3) @(negedge clk);
    #1;
    chk("sw_memwrite_state", bus.State,    4'd5);
    chk("sw_memwrite_on",    bus.MemWrite, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_memwrite", bus.MemWrite, 1'b0);
    chk("abort_state",    bus.State,    4'd0);
    chk("abort_irwrite",  bus.IRWrite,  1'b0);
    chk("abort_pcwrite",  bus.PCWrite,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_state",   bus.State,   4'd0);
    chk("restart_irwrite", bus.IRWrite, 1'b1);
    @(negedge clk); #1;
    chk("restart_decode",  bus.State,   4'd1);
    $display("abort in MEMWRITE: state=%0d memwrite=%0b", bus.State, bus.MemWrite);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
